// File: rtl/hack_rom_loader.sv
// hack_rom_loader: instruction memory for the HACK CPU, filled from a
// length-prefixed big-endian byte stream before the CPU is released.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous active-low reset
//   in_data    in   [7:0] image byte
//   in_valid   in   in_data valid
//   in_ready   out  loader accepts a byte this cycle
//   start      in   reload request, honoured only when done
//   pc         in   [ADDR_W-1:0] CPU program counter
//   inst       out  [15:0] instruction at pc (combinational)
//   cpu_reset  out  holds the CPU in reset until the image is loaded
//   done       out  image fully loaded
//   err        out  image length rejected
//   count      out  [15:0] number of valid words from the header
module hack_rom_loader #(
   parameter int ADDR_W = 15,
   parameter int DEPTH  = 32768
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              start,
   input  logic [ADDR_W-1:0] pc,
   output logic [15:0]       inst,
   output logic              cpu_reset,
   output logic              done,
   output logic              err,
   output logic [15:0]       count
);

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_W_HI,
      S_W_LO,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

   state_t            r_state;
   logic [15:0]       r_count;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_hi;
   logic [15:0]       r_mem [DEPTH];

   logic              w_xfer;
   logic              w_we;
   logic [15:0]       w_len;
   logic [16:0]       w_last;
   logic [16:0]       w_waddr17;
   logic [16:0]       w_pc17;

   assign in_ready  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                      (r_state == S_W_HI)   || (r_state == S_W_LO);
   assign done      = (r_state == S_DONE);
   assign err       = (r_state == S_ERR);
   assign cpu_reset = (r_state != S_DONE);
   assign count     = r_count;

   assign w_xfer    = in_valid && in_ready;
   assign w_len     = {r_count[15:8], in_data};
   // Only used in W_LO, where count >= 1, so no underflow.
   assign w_last    = {1'b0, r_count} - 17'd1;
   assign w_waddr17 = {{(17-ADDR_W){1'b0}}, r_waddr};
   assign w_pc17    = {{(17-ADDR_W){1'b0}}, pc};
   assign w_we      = reset && (r_state == S_W_LO) && w_xfer;

   // Reads beyond count hit stale words from earlier images; gate them.
   assign inst = (cpu_reset || (w_pc17 >= {1'b0, r_count})) ?
                 16'h0000 : r_mem[pc];

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_waddr] <= {r_hi, in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_LEN_HI;
         r_count <= '0;
         r_waddr <= '0;
         r_hi    <= '0;
      end else begin
         unique case (r_state)
            S_LEN_HI: begin
               if (w_xfer) begin
                  r_count[15:8] <= in_data;
                  r_state       <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (w_xfer) begin
                  r_count[7:0] <= in_data;
                  r_waddr      <= '0;
                  if (w_len == 16'd0) begin
                     r_state <= S_DONE;
                  end else if ({1'b0, w_len} > LP_DEPTH) begin
                     r_state <= S_ERR;
                  end else begin
                     r_state <= S_W_HI;
                  end
               end
            end
            S_W_HI: begin
               if (w_xfer) begin
                  r_hi    <= in_data;
                  r_state <= S_W_LO;
               end
            end
            S_W_LO: begin
               if (w_xfer) begin
                  if (w_waddr17 == w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_waddr <= r_waddr + 1'b1;
                     r_state <= S_W_HI;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  r_count <= '0;
                  r_state <= S_LEN_HI;
               end
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_LEN_HI;
            end
         endcase
      end
   end

endmodule
